// File: rtl/cape_et_sequencer.sv
// Job sequencer for one cape_ET stochastic-number generator: loads an operand set,
// pulses the generator reset, counts ones per stream until done, returns the result.
module cape_et_sequencer #(
  parameter int WIDTH      = 4,
  parameter int NUM_INPUTS = 2,
  parameter int CNT_W      = NUM_INPUTS*WIDTH+1,
  parameter int MAX_LEN    = 2**(NUM_INPUTS*WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_INPUTS*WIDTH-1:0] in_bxs,
  output logic                        se_rst_n,
  output logic [NUM_INPUTS*WIDTH-1:0] se_bxs,
  input  logic                        se_done,
  input  logic [NUM_INPUTS-1:0]       se_xs,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_INPUTS*CNT_W-1:0] out_cnts,
  output logic [CNT_W-1:0]            out_len,
  output logic                        out_timeout,
  output logic                        busy
);

  // state  | meaning
  // IDLE   | waiting for an operand set
  // LOAD   | cape_ET held in reset for one cycle
  // RUN    | counting stream bits until se_done or MAX_LEN
  // RESULT | result offered until out_ready
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  localparam logic [CNT_W-1:0] MAX_LEN_C = CNT_W'(MAX_LEN);

  logic [1:0]       state;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] cnt [NUM_INPUTS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      se_bxs      <= '0;
      len         <= '0;
      out_timeout <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) cnt[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            se_bxs      <= in_bxs;
            len         <= '0;
            out_timeout <= 1'b0;
            for (int i = 0; i < NUM_INPUTS; i++) cnt[i] <= '0;
            state       <= S_LOAD;
          end
        end
        S_LOAD: state <= S_RUN;
        S_RUN: begin
          // done takes priority over the length limit, so a stream of exactly MAX_LEN is not a timeout
          if (se_done) begin
            state <= S_RESULT;
          end else if (len == MAX_LEN_C) begin
            out_timeout <= 1'b1;
            state       <= S_RESULT;
          end else begin
            len <= len + 1'b1;
            for (int i = 0; i < NUM_INPUTS; i++) cnt[i] <= cnt[i] + CNT_W'(se_xs[i]);
          end
        end
        S_RESULT: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // rst_n gates the status outputs so they read inactive for the whole reset cycle
  assign in_ready  = rst_n && (state == S_IDLE);
  assign busy      = rst_n && (state != S_IDLE);
  assign out_valid = rst_n && (state == S_RESULT);
  assign se_rst_n  = rst_n && (state != S_LOAD);
  assign out_len   = len;

  always_comb begin
    out_cnts = '0;
    for (int i = 0; i < NUM_INPUTS; i++) out_cnts[i*CNT_W +: CNT_W] = cnt[i];
  end

endmodule
